// File: rtl/hwpe_stream_realign_addrgen_pkg.sv
// Shared types for the realigning 2D address generator: job descriptor,
// status flags and FSM state encoding.
package hwpe_stream_realign_addrgen_pkg;

    localparam int unsigned REALIGN_ADDR_WIDTH = 32;
    localparam int unsigned REALIGN_CNT_WIDTH  = 16;

    typedef struct packed {
        logic [REALIGN_ADDR_WIDTH-1:0] base_addr;
        logic [REALIGN_CNT_WIDTH-1:0]  line_length;
        logic [REALIGN_ADDR_WIDTH-1:0] line_stride;
        logic [REALIGN_CNT_WIDTH-1:0]  nb_lines;
    } ctrl_realign_addrgen_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic realign;
    } flags_realign_addrgen_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } realign_addrgen_state_e;

endpackage

// File: rtl/hwpe_stream_realign_addrgen_if.sv
// Address-request bus from the address generator to the source realigner:
// word address handshake plus per-word strobe and framing flags.
interface hwpe_stream_realign_addrgen_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] addr_o;
    logic                  addr_valid_o;
    logic                  addr_ready_i;
    logic [NB-1:0]         strb_o;
    logic                  first_o;
    logic                  last_o;
    logic                  last_packet_o;
    logic                  strb_valid_o;

    modport master (
        output addr_o, addr_valid_o, strb_o, first_o, last_o, last_packet_o, strb_valid_o,
        input  addr_ready_i
    );

    modport slave (
        input  addr_o, addr_valid_o, strb_o, first_o, last_o, last_packet_o, strb_valid_o,
        output addr_ready_i
    );

endinterface

// File: rtl/hwpe_stream_realign_addrgen.sv
// Word-aligned 2D address generator with realignment control; a misaligned line
// issues one extra word. Optional stall counter: HWPE_REALIGN_ADDRGEN_PERF_EN.
module hwpe_stream_realign_addrgen
    import hwpe_stream_realign_addrgen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  line_length_i,
    input  logic [ADDR_WIDTH-1:0] line_stride_i,
    input  logic [CNT_WIDTH-1:0]  nb_lines_i,
    hwpe_stream_realign_addrgen_if.master req,
    output logic                  realign_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef HWPE_REALIGN_ADDRGEN_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    localparam int unsigned NB   = DATA_WIDTH / 8;
    localparam int unsigned OFS  = $clog2(NB);
    localparam int unsigned WC_W = CNT_WIDTH + 1;

    realign_addrgen_state_e state_q, state_d;
    logic [OFS-1:0]         ofs_q, ofs_d;
    logic                   realign_q, realign_d;
    logic [ADDR_WIDTH-1:0]  line_base_q, line_base_d;
    logic [ADDR_WIDTH-1:0]  stride_q, stride_d;
    logic [WC_W-1:0]        wpl_q, wpl_d;
    logic [CNT_WIDTH-1:0]   nb_lines_q, nb_lines_d;
    logic [WC_W-1:0]        word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0]   line_cnt_q, line_cnt_d;

    logic                   run;
    logic                   hs;
    logic                   is_first;
    logic                   is_last;
    logic                   is_last_line;
    logic                   start_mis;
    flags_realign_addrgen_t flags;

    function automatic logic [NB-1:0] gen_strb(
        input logic           realign,
        input logic           first,
        input logic           last,
        input logic [OFS-1:0] ofs
    );
        logic [NB-1:0] ones;
        ones = '1;
        if (!realign) return ones;
        if (first)    return ones << ofs;
        if (last)     return ~(ones << ofs);
        return ones;
    endfunction

    assign run          = (state_q == RUN);
    assign hs           = run & req.addr_ready_i;
    assign is_first     = (word_cnt_q == '0);
    assign is_last      = (word_cnt_q == wpl_q - 1'b1);
    assign is_last_line = (line_cnt_q == nb_lines_q - 1'b1);
    assign start_mis    = |base_addr_i[OFS-1:0];

    always_comb begin
        state_d     = state_q;
        ofs_d       = ofs_q;
        realign_d   = realign_q;
        line_base_d = line_base_q;
        stride_d    = stride_q;
        wpl_d       = wpl_q;
        nb_lines_d  = nb_lines_q;
        word_cnt_d  = word_cnt_q;
        line_cnt_d  = line_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    ofs_d       = base_addr_i[OFS-1:0];
                    realign_d   = start_mis;
                    line_base_d = {base_addr_i[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
                    stride_d    = line_stride_i;
                    nb_lines_d  = nb_lines_i;
                    wpl_d       = {1'b0, line_length_i} + WC_W'(start_mis);
                    word_cnt_d  = '0;
                    line_cnt_d  = '0;
                    state_d     = (line_length_i == '0 || nb_lines_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    if (is_last) begin
                        word_cnt_d  = '0;
                        line_cnt_d  = line_cnt_q + 1'b1;
                        line_base_d = line_base_q + stride_q;
                        if (is_last_line) state_d = DONE;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Clear overrides any transition, including a same-cycle start.
        if (clear_i) begin
            state_d     = IDLE;
            ofs_d       = '0;
            realign_d   = 1'b0;
            line_base_d = '0;
            stride_d    = '0;
            wpl_d       = '0;
            nb_lines_d  = '0;
            word_cnt_d  = '0;
            line_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ofs_q       <= '0;
            realign_q   <= 1'b0;
            line_base_q <= '0;
            stride_q    <= '0;
            wpl_q       <= '0;
            nb_lines_q  <= '0;
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ofs_q       <= ofs_d;
            realign_q   <= realign_d;
            line_base_q <= line_base_d;
            stride_q    <= stride_d;
            wpl_q       <= wpl_d;
            nb_lines_q  <= nb_lines_d;
            word_cnt_q  <= word_cnt_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

    // Request outputs are purely state-derived, so they stay stable under backpressure.
    assign req.addr_valid_o  = run;
    assign req.addr_o        = run ? line_base_q + (ADDR_WIDTH'(word_cnt_q) << OFS) : '0;
    assign req.strb_o        = run ? gen_strb(realign_q, is_first, is_last, ofs_q) : '0;
    assign req.first_o       = run & is_first;
    assign req.last_o        = run & is_last;
    assign req.last_packet_o = run & is_last & is_last_line;
    assign req.strb_valid_o  = hs;

    always_comb begin
        flags.busy    = (state_q != IDLE);
        flags.done    = (state_q == DONE);
        flags.realign = realign_q;
    end

    assign busy_o    = flags.busy;
    assign done_o    = flags.done;
    assign realign_o = flags.realign;

`ifdef HWPE_REALIGN_ADDRGEN_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clear_i || (state_q == IDLE && start_i)) begin
            stall_cnt_d = '0;
        end else if (run && !req.addr_ready_i && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
